// File: rtl/store_buffer.sv
// Posted-write store buffer: formats sb/sh/sw into word writes, queues, drains via req/ack.
// Ports: clk, rst(async low), d_* CPU side, m_* memory side, stall, err, level. Option: STORE_BUFFER_COALESCE_EN.
package store_buffer_pkg;
  typedef enum logic [2:0] {
    MEM_DT_BYTE  = 3'd0,
    MEM_DT_HALF  = 3'd1,
    MEM_DT_WORD  = 3'd2,
    MEM_DT_BYTEU = 3'd3,
    MEM_DT_HALFU = 3'd4
  } mem_dt_e;

  typedef enum logic {
    ENONE  = 1'b0,
    EALIGN = 1'b1
  } errno_e;
endpackage

import store_buffer_pkg::*;

module store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      d_addr,
  input  logic [31:0]      d_wd,
  input  logic             d_we,
  input  mem_dt_e          d_dt,
  input  logic             d_re,
  output logic             stall,
  output errno_e           err,
  output logic             m_req,
  output logic [29:0]      m_addr,
  output logic [31:0]      m_wd,
  output logic [3:0]       m_be,
  input  logic             m_ack,
  output logic [PTR_W:0]   level
);

  localparam int LVL_W = PTR_W + 1;

  logic [29:0]      addr_q [DEPTH];
  logic [29:0]      addr_d [DEPTH];
  logic [31:0]      wd_q   [DEPTH];
  logic [31:0]      wd_d   [DEPTH];
  logic [3:0]       be_q   [DEPTH];
  logic [3:0]       be_d   [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             m_req_q, m_req_d;
  errno_e           err_q, err_d;

  logic [3:0]       fmt_be;
  logic [31:0]      fmt_wd;
  logic             aligned;
  logic             is_b, is_h, is_w;
  logic             full, ld_hazard;
  logic             push, pop, merge;
  logic [PTR_W-1:0] tail_last;

  assign is_b = (d_dt == MEM_DT_BYTE) || (d_dt == MEM_DT_BYTEU);
  assign is_h = (d_dt == MEM_DT_HALF) || (d_dt == MEM_DT_HALFU);
  assign is_w = (d_dt == MEM_DT_WORD);

  always_comb begin
    fmt_be  = 4'b0000;
    fmt_wd  = 32'h0;
    aligned = 1'b0;
    unique case (1'b1)
      is_b: begin
        aligned = 1'b1;
        fmt_be  = 4'b0001 << d_addr[1:0];
        fmt_wd  = {4{d_wd[7:0]}};
      end
      is_h: begin
        aligned = ~d_addr[0];
        fmt_be  = d_addr[1] ? 4'b1100 : 4'b0011;
        fmt_wd  = {2{d_wd[15:0]}};
      end
      is_w: begin
        aligned = (d_addr[1:0] == 2'b00);
        fmt_be  = 4'b1111;
        fmt_wd  = d_wd;
      end
      default: begin
        aligned = 1'b0;
      end
    endcase
  end

  always_comb begin
    ld_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && addr_q[i] == d_addr[31:2]) begin
        ld_hazard = d_re;
      end
    end
  end

  assign full      = (level_q == LVL_W'(DEPTH));
  assign stall     = (d_we & full) | ld_hazard;
  assign pop       = m_req_q & m_ack;
  assign tail_last = tail_q - PTR_W'(1);

`ifdef STORE_BUFFER_COALESCE_EN
  // Only the tail can absorb a store, and only once it is not the head,
  // so the word under handshake never changes.
  assign merge = d_we & aligned & ~full & ~stall
               & (level_q >= LVL_W'(2))
               & valid_q[tail_last]
               & (addr_q[tail_last] == d_addr[31:2]);
`else
  assign merge = 1'b0;
`endif

  assign push = d_we & aligned & ~full & ~merge;

  always_comb begin
    addr_d  = addr_q;
    wd_d    = wd_q;
    be_d    = be_q;
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    err_d   = err_q;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    if (push) begin
      addr_d[tail_q]  = d_addr[31:2];
      wd_d[tail_q]    = fmt_wd;
      be_d[tail_q]    = fmt_be;
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PTR_W'(1);
    end
    if (merge) begin
      for (int b = 0; b < 4; b++) begin
        if (fmt_be[b]) begin
          wd_d[tail_last][8*b +: 8] = fmt_wd[8*b +: 8];
        end
      end
      be_d[tail_last] = be_q[tail_last] | fmt_be;
    end
    if (d_we) begin
      err_d = aligned ? ENONE : EALIGN;
    end
    level_d = level_q + LVL_W'(push) - LVL_W'(pop);
    m_req_d = (level_d != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        wd_q[i]   <= '0;
        be_q[i]   <= '0;
      end
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= '0;
      m_req_q <= 1'b0;
      err_q   <= ENONE;
    end else begin
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      be_q    <= be_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      level_q <= level_d;
      m_req_q <= m_req_d;
      err_q   <= err_d;
    end
  end

  assign m_req  = m_req_q;
  assign m_addr = m_req_q ? addr_q[head_q] : 30'h0;
  assign m_wd   = m_req_q ? wd_q[head_q]   : 32'h0;
  assign m_be   = m_req_q ? be_q[head_q]   : 4'h0;
  assign err    = err_q;
  assign level  = level_q;

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the CPU data port (d_addr/d_wd/d_we/d_dt) and the data-memory write port.
- Converts sb/sh/sw stores into word-aligned writes with byte enables, queues them in a FIFO, and drains them to memory over a req/ack handshake.
- Flags misaligned stores.
- Raises a load-hazard stall when a load targets a word still pending in the buffer.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- d_addr  input  32  CPU store/load byte address.
- d_wd  input  32  CPU store data, right-justified.
- d_we  input  1  store request, held until accepted.
- d_dt  input  mem_dt_e  access size: MEM_DT_BYTE, MEM_DT_HALF or MEM_DT_WORD. Unsigned variants are treated as their signed size.
- d_re  input  1  load request this cycle.
- stall  output  1  CPU must hold its current instruction.
- err  output  errno_e  ENONE or EALIGN; status of the last store attempt.
- m_req  output  1  head entry valid toward memory.
- m_addr  output  30  word address of the head entry (byte address [31:2]).
- m_wd  output  32  lane-positioned data of the head entry.
- m_be  output  4  byte enables of the head entry.
- m_ack  input  1  memory accepted head entry this cycle.
- level  output  PTR_W+1  number of valid entries.

Behaviour:
- Reset (rst=0, async): pointers and level=0, all entries invalid, m_req=0, stall=0, err=ENONE, m_addr/m_wd/m_be=0.
  - Reset during a pending m_req: the transaction is abandoned and m_req drops immediately.
- Lane formatting, lane = d_addr[1:0]:
  - BYTE: be = 1<<lane; data = {4{d_wd[7:0]}}.
  - HALF: d_addr[0] must be 0; be = d_addr[1] ? 4'b1100 : 4'b0011; data = {2{d_wd[15:0]}}.
  - WORD: d_addr[1:0] must be 0; be = 4'b1111; data = d_wd.
- Misaligned store:
  - Not enqueued; no stall.
  - err=EALIGN from the next edge.
- Any aligned store attempt sets err=ENONE at the next edge. err holds between store attempts.
- Accept rule: a store is enqueued on the edge where d_we=1, it is aligned, and level<DEPTH.
- stall = (d_we & level==DEPTH) | ld_hazard, combinational.
  - A full buffer stalls even if m_ack pops an entry in the same cycle; the store is accepted on the next cycle.
- Drain side:
  - m_req = (level!=0), registered.
  - m_addr/m_wd/m_be come from the head entry and stay stable while m_req=1 and m_ack=0.
  - Pop on the edge where m_req & m_ack.
  - m_ack while m_req=0 is ignored.
- Latency: a store accepted into an empty buffer at edge N shows m_req=1 after edge N. With m_ack tied high it is written at edge N+1.
- Simultaneous push and pop: level is unchanged and both pointers advance. With level==1, head moves to the new entry.
- Pointers wrap modulo DEPTH.
- ld_hazard = d_re & (some valid entry has m_addr == d_addr[31:2]); the comparison is combinational.
  - The load stalls until matching entries have drained. No forwarding.
- Ordering: strict FIFO; memory sees stores in program order.

Optional Feature:
- Macro: STORE_BUFFER_COALESCE_EN.
- Defined: an aligned store whose word address equals the tail (most recent) entry is merged into that entry when level>=2 and the buffer is not full or stalled.
  - Merge: data lanes with new be overwrite; be |= new be.
  - No new entry is allocated; level is unchanged.
  - The head entry (level==1) is never merged, so m_wd/m_be stay stable during the handshake.
- Undefined: every accepted store allocates a new entry.

Test Plan:
- Reset, then sh 0xdeadc0de to 0x122, m_ack=1 -> next cycle m_req=1, m_addr=0x48, m_be=4'b1100, m_wd=0xc0dec0de. The cycle after: level=0, m_req=0.
- m_ack=0, issue 5 aligned sw (0x100..0x110) -> level=4. stall=1 on the 5th, which is accepted after one ack. Drain order is 0x40..0x44.
- sh to 0x121 -> err=EALIGN, level unchanged, no stall. Next sb to 0x121 -> err=ENONE, be=4'b0010.
- m_ack=0 with a pending sw to 0x200: d_re to 0x202 -> stall=1; d_re to 0x204 -> stall=0. Assert m_ack -> stall clears the following cycle.
- Drop rst mid-handshake with level=3 -> m_req=0 and level=0 asynchronously. After release, no stale writes appear.
- With STORE_BUFFER_COALESCE_EN, m_ack=0: sw 0x300=0x11111111, sb 0x304=0xaa, sb 0x305=0xbb -> level=2. Second entry has be=4'b0011, m_wd[15:0]=0xbbaa. Without the macro -> level=3.
